// File: rtl/instr_encoder_pkg.sv
// Class codes and RV32I opcodes shared by the instruction encoder and the control decoder.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_IMM    = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_JALR   = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JAL    = 3'd6,
        CLS_ILL    = 3'd7
    } cls_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // SLLI/SRLI/SRAI use a 5-bit shamt and carry funct7 instead of a 12-bit immediate
    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO; the head word comes straight from the storage registers.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_q];

    // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs field-level commands into RV32I words, queues them and emits them with a byte address.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_class,
    input  logic [2:0]        cmd_funct3,
    input  logic              cmd_f7b5,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rs1,
    input  logic [4:0]        cmd_rs2,
    input  logic [20:0]       cmd_imm,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [31:0]       ins_word,
    output logic [ADDR_W-1:0] ins_addr,
    output logic              err_imm,
    output logic              err_class
);
    cls_e              cls;
    logic signed [20:0] imm_s;
    logic [31:0]       word_d;
    logic              imm_bad_d;
    logic              lo12_oor;
    logic              accept, push, pop;
    logic              full, empty;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_imm_q, err_cls_q;

    assign cls      = cls_e'(cmd_class);
    assign imm_s    = $signed(cmd_imm);
    assign lo12_oor = (imm_s < -21'sd2048) || (imm_s > 21'sd2047);

    // Field packing and immediate range check for the presented command
    always_comb begin
        word_d    = '0;
        imm_bad_d = 1'b0;
        unique case (cls)
            CLS_R: word_d = {1'b0, cmd_f7b5, 5'b0, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, OP_R};
            CLS_LOAD: begin
                word_d    = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, OP_LOAD};
                imm_bad_d = lo12_oor;
            end
            CLS_IMM: begin
                if (is_shift(cmd_funct3)) begin
                    word_d    = {1'b0, cmd_f7b5, 5'b0, cmd_imm[4:0], cmd_rs1, cmd_funct3, cmd_rd, OP_IMM};
                    imm_bad_d = (imm_s < 21'sd0) || (imm_s > 21'sd31);
                end else begin
                    word_d    = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, OP_IMM};
                    imm_bad_d = lo12_oor;
                end
            end
            CLS_STORE: begin
                word_d    = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_imm[4:0], OP_STORE};
                imm_bad_d = lo12_oor;
            end
            CLS_JALR: begin
                word_d    = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, OP_JALR};
                imm_bad_d = lo12_oor;
            end
            CLS_BRANCH: begin
                word_d    = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_funct3,
                             cmd_imm[4:1], cmd_imm[11], OP_BRANCH};
                imm_bad_d = (imm_s < -21'sd4096) || (imm_s > 21'sd4094) || cmd_imm[0];
            end
            CLS_JAL: begin
                word_d    = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12], cmd_rd, OP_JAL};
                imm_bad_d = cmd_imm[0];
            end
            default: begin
                word_d    = '0;
                imm_bad_d = 1'b0;
            end
        endcase
    end

    // Illegal commands are consumed but never queued; flush discards the push entirely
    assign accept = cmd_valid & cmd_ready;
    assign push   = accept & ~flush & (cls != CLS_ILL);
    assign pop    = ins_valid & ins_ready;

    instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .push_i  (push),
        .din_i   (word_d),
        .pop_i   (pop),
        .dout_o  (ins_word),
        .full_o  (full),
        .empty_o (empty)
    );

    assign cmd_ready = ~full;
    assign ins_valid = ~empty;
    assign ins_addr  = addr_q;
    assign err_imm   = err_imm_q;
    assign err_class = err_cls_q;

    // Address of the head word advances only when a word leaves
    always_comb begin
        addr_d = addr_q;
        if (flush)    addr_d = BASE_ADDR;
        else if (pop) addr_d = addr_q + ADDR_W'(4);
    end

    // Address register and one-cycle error pulses for accepted commands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= BASE_ADDR;
            err_imm_q <= 1'b0;
            err_cls_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            err_imm_q <= push & imm_bad_d;
            err_cls_q <= accept & ~flush & (cls == CLS_ILL);
        end
    end

endmodule
